rf_bank: RTL
============

Name: rf_bank

Overview:
- Parametrised multi-port integer register file for the next-generation pipelined core. Replaces the single-issue 2R1W register file.
- Adds configurable width, depth and read/write port counts.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard (set at issue, cleared at writeback, bulk-cleared on flush).
- Sits between decode/issue (read, busy check, issue), the writeback stage (write ports) and the difftest/debug harness (debug read port).

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the registered value.
- ZERO_R0, 1, 1 = register 0 reads zero, ignores writes, and is never busy.
- AW, $clog2(NREG), derived address width; not overridable.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rs_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rs_data  out  NRD*XLEN  read data, combinational.
- rs_busy  out  NRD  busy bit of each read address, combinational.
- wen  in  NWR  write enables.
- waddr  in  NWR*AW  write addresses.
- wdata  in  NWR*XLEN  write data.
- iss_valid  in  1  an instruction with destination iss_rd is issuing.
- iss_rd  in  AW  issuing destination register.
- flush  in  1  pipeline flush; clears all busy bits.
- dbg_addr  in  AW  debug/difftest read address.
- dbg_data  out  XLEN  debug read data; raw registered value, never bypassed.

Behaviour:
- Reset:
  - While reset=0, all NREG registers are 0 and all busy bits are 0, asynchronously.
  - rs_data, dbg_data and rs_busy are therefore 0 during reset.
  - Writes, issue and flush are ignored during reset.
  - Deassertion is taken synchronously to clock by the surrounding reset synchroniser; the block assumes clean release.
- Write:
  - A register updates on the rising edge when wen[j]=1; latency 1.
  - If ZERO_R0=1 and waddr[j]=0, the write is dropped.
  - If two write ports target the same address in one cycle, the higher port index wins.
- Read:
  - rs_data[i] = rf[rs_addr[i]], combinational.
  - If BYPASS=1 and some wen[j] with waddr[j]==rs_addr[i] is active (and the address is not r0 when ZERO_R0=1), wdata of the highest such j is returned instead.
  - If ZERO_R0=1, reading r0 returns 0 regardless of bypass.
- Scoreboard (per-register busy bits, updated at the rising edge):
  - iss_valid=1 sets busy[iss_rd].
  - wen[j]=1 clears busy[waddr[j]].
  - Issue and write to the same register in one cycle: the set wins (a new producer supersedes the old one).
  - flush=1 clears every busy bit and overrides a same-cycle iss_valid. Register contents are unaffected by flush; writes in a flush cycle still commit.
  - ZERO_R0=1: busy[0] is held at 0.
  - rs_busy[i] = busy[rs_addr[i]], pre-edge value. With BYPASS=1, a same-cycle write to rs_addr[i] forces rs_busy[i]=0, unless iss_valid targets the same register in that cycle (set wins; the pre-edge value is reported).
- Out-of-range addresses cannot occur because NREG is a power of two.
- The DPI hook registering the register array with the simulator stays in this block under `ifdef SIMULATION`. dbg_data is the synthesisable equivalent.

Decomposition:
- Shared package rf_pkg:
  - default XLEN, NREG and REG_AW constants;
  - typedef reg_addr_t (logic [REG_AW-1:0]) and xlen_t;
  - function sel_wr_hit(addr, wen, waddr), returning the hit flag and the winning port index (used for both bypass and the priority write).
- Sub-module rf_scoreboard (NREG, NWR, ZERO_R0): busy vector, set/clear/flush priority logic, NRD busy lookups. The data array and bypass muxes stay in rf_bank.

Test Plan:
- Reset check: hold reset=0 with wen[0]=1, waddr=5, wdata=0xDEAD -> rs_data=0 and dbg_data(5)=0. After release, read r5 -> 0 and rs_busy=0.
- Write then read: write r7=0x1234_5678_9ABC_DEF0 at edge N. Read r7 at cycle N+1 -> same value. Write r0=0xFFFF and read r0 -> 0.
- Bypass: BYPASS=1, rs_addr[0]=3 while wen[0]=1, waddr=3, wdata=0xAA in the same cycle -> rs_data[0]=0xAA, dbg_data(3)=old value. Repeat with BYPASS=0 -> old value.
- Dual write conflict: NWR=2, both ports write r9 (0x11 on port 0, 0x22 on port 1) -> r9=0x22. Bypassed read in that cycle -> 0x22.
- Scoreboard:
  - Issue r4 -> rs_busy=1 next cycle.
  - Writeback r4 -> rs_busy=0 next cycle, and 0 in the same cycle with BYPASS=1.
  - Issue r4 plus writeback r4 in one cycle -> busy stays 1.
- Flush: set busy on r1, r2, r3. Assert flush together with iss_valid on r6 -> all busy bits 0 next cycle, including r6. Register contents unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the integer register file.
// Write-port hit detection is shared by the write array and bypass muxes.
package rf_pkg;

    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int REG_AW  = $clog2(NREG);
    localparam int MAX_NWR = 2;
    localparam int MAX_AW  = 16;
    localparam int WR_IW   = 1;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    typedef struct packed {
        logic             hit;
        logic [WR_IW-1:0] idx;
    } wr_hit_t;

    // Highest-numbered enabled port matching addr wins.
    function automatic wr_hit_t sel_wr_hit(
        input logic [MAX_AW-1:0]         addr,
        input logic [MAX_NWR-1:0]        wen,
        input logic [MAX_NWR*MAX_AW-1:0] waddr
    );
        wr_hit_t r;
        r = '0;
        for (int j = 0; j < MAX_NWR; j++) begin
            if (wen[j] && (waddr[j*MAX_AW +: MAX_AW] == addr)) begin
                r.hit = 1'b1;
                r.idx = WR_IW'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, flushed in bulk.
// Lookups report the pre-edge state, optionally cleared by a same-cycle write.
module rf_scoreboard #(
    parameter  int NREG    = 32,
    parameter  int NWR     = 1,
    parameter  int NRD     = 2,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy
);
    import rf_pkg::*;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nx;

    // Priority, lowest to highest: clear, set, flush, r0 hold.
    always_comb begin
        busy_nx = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j]) begin
                busy_nx[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_nx[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_nx = '0;
        end
        if (ZERO_R0 != 0) begin
            busy_nx[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nx;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        logic          wr;
        logic          b;
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rs_addr[i*AW +: AW];
            b  = busy[ra];
            wr = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
                    wr = 1'b1;
                end
            end
            if ((BYPASS != 0) && wr && !(iss_valid && (iss_rd == ra))) begin
                b = 1'b0;
            end
            rs_busy[i] = b;
        end
    end

endmodule

// File: rtl/rf_bank.sv
// Multi-port integer register file with write bypass and busy scoreboard.
// dbg_data exposes the raw registered array for difftest.
module rf_bank #(
    parameter  int XLEN    = rf_pkg::XLEN,
    parameter  int NREG    = rf_pkg::NREG,
    parameter  int NRD     = 2,
    parameter  int NWR     = 1,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    import rf_pkg::*;

    logic [XLEN-1:0]           rf [NREG];
    logic [NWR-1:0]            wen_q;
    logic [MAX_NWR-1:0]        wen_x;
    logic [MAX_NWR*MAX_AW-1:0] wa_x;
    wr_hit_t                   whit [NREG];

    // Writes are ignored while reset is held, including for bypass.
    assign wen_q = wen & {NWR{reset}};

    always_comb begin
        wen_x = '0;
        wa_x  = '0;
        for (int j = 0; j < NWR; j++) begin
            wen_x[j]                   = wen_q[j];
            wa_x[j*MAX_AW +: MAX_AW]   = MAX_AW'(waddr[j*AW +: AW]);
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            whit[r] = sel_wr_hit(MAX_AW'(r), wen_x, wa_x);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (whit[r].hit && !((ZERO_R0 != 0) && (r == 0))) begin
                    rf[r] <= wdata[int'(whit[r].idx)*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        wr_hit_t         h;
        logic [XLEN-1:0] d;
        rs_data = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rs_addr[i*AW +: AW];
            h  = sel_wr_hit(MAX_AW'(ra), wen_x, wa_x);
            d  = rf[ra];
            if ((BYPASS != 0) && h.hit) begin
                d = wdata[int'(h.idx)*XLEN +: XLEN];
            end
            if ((ZERO_R0 != 0) && (ra == '0)) begin
                d = '0;
            end
            rs_data[i*XLEN +: XLEN] = d;
        end
    end

    assign dbg_data = rf[dbg_addr];

    rf_scoreboard #(
        .NREG    (NREG),
        .NWR     (NWR),
        .NRD     (NRD),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clock     (clock),
        .reset     (reset),
        .wen       (wen_q),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .rs_addr   (rs_addr),
        .rs_busy   (rs_busy)
    );

endmodule
